// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the LSU memory controller.
//   state_e : controller FSM states
//   F3_*    : load/store funct3 encodings
//   cause_e : response error cause codes
package lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StResp
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CauseNone       = 2'b00,
    CauseMisaligned = 2'b01,
    CauseIllegal    = 2'b10,
    CauseTimeout    = 2'b11
  } cause_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of pipeline request/response, data memory and lsu aligner signals around the
// controller. Suffixes are from the controller's point of view.
//   master : controller side (drives *_o, reads *_i)
//   slave  : environment side (pipeline, memory and lsu)
interface lsu_mem_ctrl_if;
  // Pipeline request
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_is_store_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  // Pipeline response
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [1:0]  rsp_cause_o;
  // Data memory
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  // lsu aligner
  logic [31:0] lsu_load_data_o;
  logic [31:0] lsu_store_data_o;
  logic [2:0]  lsu_funct3_o;
  logic [1:0]  lsu_byte_offset_o;
  logic        lsu_load_or_store_o;
  logic [31:0] lsu_result_i;

  modport master (
    input  req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, lsu_result_i,
    output req_ready_o, stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_cause_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output lsu_load_data_o, lsu_store_data_o, lsu_funct3_o, lsu_byte_offset_o,
    output lsu_load_or_store_o
  );

  modport slave (
    output req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, lsu_result_i,
    input  req_ready_o, stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_cause_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  lsu_load_data_o, lsu_store_data_o, lsu_funct3_o, lsu_byte_offset_o,
    input  lsu_load_or_store_o
  );
endinterface

// File: rtl/lsu_access_chk.sv
// Combinational legality check of a load/store request.
//   is_store_i   : 1 = store
//   funct3_i     : access size/sign encoding
//   offset_i     : addr[1:0]
//   illegal_o    : funct3 not valid for this access type
//   misaligned_o : halfword on odd byte or word not on a word boundary
//   needs_rmw_o  : legal sub-word store (needs read-modify-write)
module lsu_access_chk
  import lsu_ctrl_pkg::*;
(
  input  logic       is_store_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] offset_i,
  output logic       illegal_o,
  output logic       misaligned_o,
  output logic       needs_rmw_o
);

  always_comb begin
    if (is_store_i) begin
      illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    case (funct3_i)
      F3_H, F3_HU: misaligned_o = offset_i[0];
      F3_W:        misaligned_o = (offset_i != 2'b00);
      default:     misaligned_o = 1'b0;
    endcase

    needs_rmw_o = is_store_i && !illegal_o && (funct3_i inside {F3_B, F3_H});
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequencer between the MEM stage, the external lsu aligner and a handshaked data memory.
// One access at a time; SB/SH are done as read-modify-write, SW as a single write.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : request/response, memory and lsu signals (master side)
// TIMEOUT bounds the cycles spent in any memory state before aborting with a timeout.
module lsu_mem_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  lsu_mem_ctrl_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  cause_e            cause_q;
  logic [CntW-1:0]   cnt_q;

  logic illegal, misaligned, needs_rmw, timeout;

  lsu_access_chk u_chk (
    .is_store_i   (bus.req_is_store_i),
    .funct3_i     (bus.req_funct3_i),
    .offset_i     (bus.req_addr_i[1:0]),
    .illegal_o    (illegal),
    .misaligned_o (misaligned),
    .needs_rmw_o  (needs_rmw)
  );

  // Last cycle allowed in a memory state; a handshake in this cycle still wins.
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cause_q    <= CauseNone;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid_i) begin
            is_store_q <= bus.req_is_store_i;
            funct3_q   <= bus.req_funct3_i;
            addr_q     <= bus.req_addr_i;
            wdata_q    <= bus.req_wdata_i;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cause_q    <= CauseNone;
            cnt_q      <= '0;
            if (illegal) begin
              err_q   <= 1'b1;
              cause_q <= CauseIllegal;
              state_q <= StResp;
            end else if (misaligned) begin
              err_q   <= 1'b1;
              cause_q <= CauseMisaligned;
              state_q <= StResp;
            end else if (bus.req_is_store_i && !needs_rmw) begin
              state_q <= StWrReq;
            end else begin
              state_q <= StRdReq;
            end
          end
        end
        StRdReq: begin
          if (bus.mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= StRdWait;
          end else if (timeout) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            cause_q <= CauseTimeout;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRdWait: begin
          if (bus.mem_rvalid_i) begin
            cnt_q <= '0;
            if (is_store_q) begin
              merge_q <= bus.mem_rdata_i;
              state_q <= StWrReq;
            end else begin
              rdata_q <= bus.lsu_result_i;
              state_q <= StResp;
            end
          end else if (timeout) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            cause_q <= CauseTimeout;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrReq: begin
          if (bus.mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= StResp;
          end else if (timeout) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            cause_q <= CauseTimeout;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode the registered state only, except stall (needs same-cycle req_valid)
  // and the lsu/memory data paths.
  always_comb begin
    bus.req_ready_o         = (state_q == StIdle);
    bus.stall_o             = ((state_q == StIdle) && bus.req_valid_i) ||
                              (state_q inside {StRdReq, StRdWait, StWrReq});
    bus.rsp_valid_o         = (state_q == StResp);
    bus.rsp_rdata_o         = rdata_q;
    bus.rsp_err_o           = err_q;
    bus.rsp_cause_o         = cause_q;
    bus.mem_req_o           = (state_q inside {StRdReq, StWrReq});
    bus.mem_we_o            = (state_q == StWrReq);
    bus.mem_addr_o          = {addr_q[31:2], 2'b00};
    bus.mem_wdata_o         = (state_q == StWrReq) ? bus.lsu_result_i : '0;
    bus.lsu_load_data_o     = (state_q == StRdWait) ? bus.mem_rdata_i : merge_q;
    bus.lsu_store_data_o    = wdata_q;
    bus.lsu_funct3_o        = funct3_q;
    bus.lsu_byte_offset_o   = addr_q[1:0];
    bus.lsu_load_or_store_o = is_store_q;
  end

endmodule
